counter_seven_seg_driver: RTL and testbench

Display stage directly downstream of the 4-bit up/down counter. It consumes the counter value (0-15), converts it to two decimal digits and time-multiplexes them onto a 2-digit common 7-segment display. It latches the value once per scan frame so a digit pair never mixes two counter values. It also emits a one-cycle pulse whenever the counter value changes.

---
 rtl/counter_seven_seg_driver_pkg.sv | 24 ++
 rtl/counter_seven_seg_driver_seg7_decoder.sv | 28 ++
 rtl/counter_seven_seg_driver.sv | 119 +++++++++++
 tb/tb_counter_seven_seg_driver.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_seven_seg_driver_pkg.sv
// Shared constants for the counter seven-segment display stage:
// segment patterns, digit-select codes and the default scan rate.
package counter_seven_seg_driver_pkg;

    localparam int REFRESH_CYCLES_DEFAULT = 50000;

    // Segment patterns, bit order {g,f,e,d,c,b,a}, active-high
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [1:0] AN_OFF  = 2'b00;
    localparam logic [1:0] AN_ONES = 2'b01;
    localparam logic [1:0] AN_TENS = 2'b10;

endpackage

// File: rtl/counter_seven_seg_driver_seg7_decoder.sv
// Combinational decimal digit to seven-segment pattern decoder.
// Codes above 9 are unreachable upstream and decode to blank.
module seg7_decoder
    import counter_seven_seg_driver_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // Digit lookup
    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/counter_seven_seg_driver.sv
// Two-digit multiplexed seven-segment driver for a 4-bit counter value,
// latched once per scan frame, plus a one-cycle value-change pulse.
module counter_seven_seg_driver
    import counter_seven_seg_driver_pkg::*;
#(
    parameter int REFRESH_CYCLES = REFRESH_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] counter,
    input  logic       enable,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       changed
);

    localparam int TW = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(REFRESH_CYCLES - 1);

    logic [3:0]    cnt_q_r;
    logic [3:0]    disp_val_r;
    logic [TW-1:0] timer_r;
    logic          digit_sel_r;

    logic          tens_s;
    logic [3:0]    ones_s;
    logic [3:0]    digit_s;
    logic [6:0]    dec_seg_s;
    logic [6:0]    seg_next_s;
    logic [1:0]    an_next_s;

    // Binary to BCD split and digit mux feeding the single decoder
    always_comb begin
        tens_s = (disp_val_r >= 4'd10);
        if (tens_s) begin
            ones_s = disp_val_r - 4'd10;
        end else begin
            ones_s = disp_val_r;
        end
        if (digit_sel_r) begin
            digit_s = 4'd1;
        end else begin
            digit_s = ones_s;
        end
    end

    seg7_decoder u_dec (
        .digit (digit_s),
        .seg   (dec_seg_s)
    );

    // Next output values; a zero tens digit is blanked but its slot still scans
    always_comb begin
        an_next_s  = AN_OFF;
        seg_next_s = SEG_BLANK;
        if (!enable) begin
            an_next_s  = AN_OFF;
            seg_next_s = SEG_BLANK;
        end else if (!digit_sel_r) begin
            an_next_s  = AN_ONES;
            seg_next_s = dec_seg_s;
        end else begin
            an_next_s = AN_TENS;
            if (tens_s) begin
                seg_next_s = dec_seg_s;
            end else begin
                seg_next_s = SEG_BLANK;
            end
        end
    end

    // Input sampler and change detector
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q_r <= 4'd0;
            changed <= 1'b0;
        end else begin
            cnt_q_r <= counter;
            changed <= (counter != cnt_q_r);
        end
    end

    // Scan timer; the displayed value is only refreshed at frame end or while disabled
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer_r     <= '0;
            digit_sel_r <= 1'b0;
            disp_val_r  <= 4'd0;
        end else if (!enable) begin
            timer_r     <= '0;
            digit_sel_r <= 1'b0;
            disp_val_r  <= cnt_q_r;
        end else if (timer_r == TIMER_LAST) begin
            timer_r     <= '0;
            digit_sel_r <= ~digit_sel_r;
            if (digit_sel_r) begin
                disp_val_r <= cnt_q_r;
            end else begin
                disp_val_r <= disp_val_r;
            end
        end else begin
            timer_r     <= timer_r + TW'(1);
            digit_sel_r <= digit_sel_r;
            disp_val_r  <= disp_val_r;
        end
    end

    // Registered display outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg <= SEG_BLANK;
            an  <= AN_OFF;
        end else begin
            seg <= seg_next_s;
            an  <= an_next_s;
        end
    end

endmodule

// File: tb/tb_counter_seven_seg_driver.sv
// Directed self-checking bench for counter_seven_seg_driver with a
// four-cycle refresh slot.
module tb_counter_seven_seg_driver;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] counter;
    logic       enable;
    logic [6:0] seg;
    logic [1:0] an;
    logic       changed;

    int n_cmp = 0;
    int n_bad = 0;

    counter_seven_seg_driver #(.REFRESH_CYCLES(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .counter (counter),
        .enable  (enable),
        .seg     (seg),
        .an      (an),
        .changed (changed)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0; enable = 1'b0; counter = 4'd0;
        step();
        step();
        n_cmp++;
        if (seg !== 7'h00 || an !== 2'b00 || changed !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_hold: seg=%h an=%b changed=%b, expected 00 00 0", seg, an, changed);
        end
        reset = 1'b1;
        step();
        n_cmp++;
        if (seg !== 7'h00 || an !== 2'b00 || changed !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release_disabled: seg=%h an=%b changed=%b, expected 00 00 0", seg, an, changed);
        end
    endtask

    task automatic test_changed();
        reset = 1'b0; counter = 4'd0; enable = 1'b0;
        step();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (changed !== 1'b0) begin
                n_bad++;
                $display("FAIL changed_after_reset cycle %0d: got %b, expected 0", i, changed);
            end
        end
        counter = 4'd1;
        for (int i = 0; i < 6; i++) begin
            step();
            n_cmp++;
            if (changed !== (i == 0)) begin
                n_bad++;
                $display("FAIL changed_0to1 cycle %0d: got %b, expected %b", i, changed, (i == 0));
            end
        end
        counter = 4'd15;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (changed !== (i == 0)) begin
                n_bad++;
                $display("FAIL changed_1to15 cycle %0d: got %b, expected %b", i, changed, (i == 0));
            end
        end
        counter = 4'd0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (changed !== (i == 0)) begin
                n_bad++;
                $display("FAIL changed_wrap_15to0 cycle %0d: got %b, expected %b", i, changed, (i == 0));
            end
        end
        counter = 4'd15;
        step();
        n_cmp++;
        if (changed !== 1'b1) begin
            n_bad++;
            $display("FAIL changed_wrap_0to15: got %b, expected 1", changed);
        end
    endtask

    task automatic test_scan_timing();
        logic [1:0] exp_an;
        logic [6:0] exp_seg;
        enable = 1'b0; counter = 4'd7;
        step(); step(); step();
        enable = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            exp_an  = (((i / 4) % 2) == 0) ? 2'b01 : 2'b10;
            exp_seg = (((i / 4) % 2) == 0) ? 7'h07 : 7'h00;
            n_cmp++;
            if (an !== exp_an || seg !== exp_seg) begin
                n_bad++;
                $display("FAIL scan_timing cycle %0d: an=%b seg=%h, expected an=%b seg=%h", i, an, seg, exp_an, exp_seg);
            end
        end
    endtask

    task automatic test_bcd();
        logic [3:0] vals  [5] = '{4'd13, 4'd10, 4'd9, 4'd0, 4'd15};
        logic [6:0] ones_e[5] = '{7'h4F, 7'h3F, 7'h6F, 7'h3F, 7'h6D};
        logic [6:0] tens_e[5] = '{7'h06, 7'h06, 7'h00, 7'h00, 7'h06};
        for (int v = 0; v < 5; v++) begin
            enable = 1'b0; counter = vals[v];
            step(); step();
            enable = 1'b1;
            for (int i = 0; i < 8; i++) begin
                step();
                n_cmp++;
                if (i < 4 && (an !== 2'b01 || seg !== ones_e[v])) begin
                    n_bad++;
                    $display("FAIL bcd_ones val=%0d cycle %0d: an=%b seg=%h, expected an=01 seg=%h", vals[v], i, an, seg, ones_e[v]);
                end else if (i >= 4 && (an !== 2'b10 || seg !== tens_e[v])) begin
                    n_bad++;
                    $display("FAIL bcd_tens val=%0d cycle %0d: an=%b seg=%h, expected an=10 seg=%h", vals[v], i, an, seg, tens_e[v]);
                end
            end
        end
    endtask

    task automatic test_no_tearing();
        enable = 1'b0; counter = 4'd13;
        step(); step();
        enable = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step();
            if (i == 0) counter = 4'd14;
            n_cmp++;
            if (i < 4 && (an !== 2'b01 || seg !== 7'h4F)) begin
                n_bad++;
                $display("FAIL tearing_ones cycle %0d: an=%b seg=%h, expected an=01 seg=4f", i, an, seg);
            end else if (i >= 4 && i < 8 && (an !== 2'b10 || seg !== 7'h06)) begin
                n_bad++;
                $display("FAIL tearing_tens cycle %0d: an=%b seg=%h, expected an=10 seg=06", i, an, seg);
            end else if (i == 8 && (an !== 2'b01 || seg !== 7'h66)) begin
                n_bad++;
                $display("FAIL tearing_next_frame: an=%b seg=%h, expected an=01 seg=66", an, seg);
            end
        end
    endtask

    task automatic test_enable_drop();
        enable = 1'b0; counter = 4'd5;
        step(); step();
        enable = 1'b1;
        for (int i = 0; i < 6; i++) step();
        n_cmp++;
        if (an !== 2'b10 || seg !== 7'h00) begin
            n_bad++;
            $display("FAIL drop_pre_tens: an=%b seg=%h, expected an=10 seg=00", an, seg);
        end
        enable = 1'b0; counter = 4'd8;
        step();
        n_cmp++;
        if (an !== 2'b00 || seg !== 7'h00) begin
            n_bad++;
            $display("FAIL drop_blank: an=%b seg=%h, expected an=00 seg=00", an, seg);
        end
        step();
        enable = 1'b1;
        step();
        n_cmp++;
        if (an !== 2'b01 || seg !== 7'h7F) begin
            n_bad++;
            $display("FAIL drop_reenable: an=%b seg=%h, expected an=01 seg=7f", an, seg);
        end
    endtask

    task automatic test_async_reset();
        enable = 1'b0; counter = 4'd13;
        step(); step();
        enable = 1'b1;
        for (int i = 0; i < 6; i++) step();
        n_cmp++;
        if (an !== 2'b10 || seg !== 7'h06) begin
            n_bad++;
            $display("FAIL async_pre: an=%b seg=%h, expected an=10 seg=06", an, seg);
        end
        #3 reset = 1'b0;
        #1;
        n_cmp++;
        if (seg !== 7'h00 || an !== 2'b00 || changed !== 1'b0) begin
            n_bad++;
            $display("FAIL async_blank: seg=%h an=%b changed=%b, expected 00 00 0", seg, an, changed);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step();
            if (i == 0) begin
                n_cmp++;
                if (an !== 2'b01 || seg !== 7'h3F || changed !== 1'b1) begin
                    n_bad++;
                    $display("FAIL async_restart: an=%b seg=%h changed=%b, expected 01 3f 1", an, seg, changed);
                end
            end else if (i == 4) begin
                n_cmp++;
                if (an !== 2'b10 || seg !== 7'h00) begin
                    n_bad++;
                    $display("FAIL async_tens: an=%b seg=%h, expected an=10 seg=00", an, seg);
                end
            end else if (i == 8) begin
                n_cmp++;
                if (an !== 2'b01 || seg !== 7'h4F) begin
                    n_bad++;
                    $display("FAIL async_next_frame: an=%b seg=%h, expected an=01 seg=4f", an, seg);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; counter = 4'd0;
        @(negedge clk);
        test_reset();
        test_changed();
        test_scan_timing();
        test_bcd();
        test_no_tearing();
        test_enable_drop();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
